// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU sequencing controller.
package npu_pkg;

    localparam int NPU_N_DEFAULT = 32;
    localparam int NPU_ADDR_W    = $clog2(NPU_N_DEFAULT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ARRAY   = 3'd2,
        QUANT   = 3'd3,
        SOFTMAX = 3'd4,
        WRBACK  = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } npu_state_e;

    // Stages guarded by the watchdog; WRBACK has a fixed length and is excluded.
    function automatic logic is_stage(input npu_state_e s);
        is_stage = (s == LOAD) || (s == ARRAY) || (s == QUANT) || (s == SOFTMAX);
    endfunction

    function automatic npu_state_e next_stage(input npu_state_e s);
        case (s)
            LOAD:    next_stage = ARRAY;
            ARRAY:   next_stage = QUANT;
            QUANT:   next_stage = SOFTMAX;
            SOFTMAX: next_stage = WRBACK;
            default: next_stage = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/npu_seq_ctrl_if.sv
// Stage start/done handshakes and output-BRAM write port of the sequencer.
interface npu_seq_ctrl_if
    import npu_pkg::*;
#(
    parameter int N = NPU_N_DEFAULT
);
    logic                 o_load_start;
    logic                 i_load_done;
    logic                 o_array_start;
    logic                 i_array_done;
    logic                 o_quant_start;
    logic                 i_quant_done;
    logic                 o_softmax_start;
    logic                 i_softmax_done;
    logic                 o_wr_en;
    logic [$clog2(N)-1:0] o_wr_addr;

    modport master (
        output o_load_start, o_array_start, o_quant_start, o_softmax_start,
        output o_wr_en, o_wr_addr,
        input  i_load_done, i_array_done, i_quant_done, i_softmax_done
    );

    modport slave (
        input  o_load_start, o_array_start, o_quant_start, o_softmax_start,
        input  o_wr_en, o_wr_addr,
        output i_load_done, i_array_done, i_quant_done, i_softmax_done
    );
endinterface

// File: rtl/npu_stage_timer.sv
// Per-stage watchdog: counts enabled cycles since the last clear.
module npu_stage_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // cnt_q equals the index of the current stage cycle, so expiry fires in cycle TIMEOUT-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = enable && (cnt_q == LIMIT);
endmodule

// File: rtl/npu_seq_ctrl.sv
// Sequencer for load -> systolic array -> quantize -> softmax -> write-back,
// with per-stage watchdog, abort and cycle-latency measurement.
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int N       = NPU_N_DEFAULT,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_abort,
    npu_seq_ctrl_if.master bus,
    output logic           o_busy,
    output logic           o_valid,
    output logic           o_error,
    output logic [2:0]     o_err_stage,
    output logic [31:0]    o_latency
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    npu_state_e    state_q, state_d;
    logic          first_q;
    logic [AW-1:0] wr_cnt_q;
    logic          stage_done;
    logic          accept;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_expired;

    assign timer_clear  = (state_d != state_q);
    assign timer_enable = is_stage(state_q);

    npu_stage_timer #(.TIMEOUT(TIMEOUT)) u_stage_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Abort outranks done, and done outranks a watchdog expiry in the same cycle.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        stage_done = 1'b0;
        case (state_q)
            LOAD:    stage_done = bus.i_load_done;
            ARRAY:   stage_done = bus.i_array_done;
            QUANT:   stage_done = bus.i_quant_done;
            SOFTMAX: stage_done = bus.i_softmax_done;
            default: stage_done = 1'b0;
        endcase
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD, ARRAY, QUANT, SOFTMAX: begin
                if (i_abort)                     state_d = IDLE;
                else if (stage_done && !first_q) state_d = next_stage(state_q);
                else if (timer_expired)          state_d = ERROR;
            end
            WRBACK: begin
                if (i_abort)                     state_d = IDLE;
                else if (wr_cnt_q == LAST_ADDR)  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy              = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign bus.o_load_start    = first_q && (state_q == LOAD);
    assign bus.o_array_start   = first_q && (state_q == ARRAY);
    assign bus.o_quant_start   = first_q && (state_q == QUANT);
    assign bus.o_softmax_start = first_q && (state_q == SOFTMAX);
    assign bus.o_wr_en         = (state_q == WRBACK) && !i_abort;
    assign bus.o_wr_addr       = (state_q == WRBACK) ? wr_cnt_q : '0;

    // first_q marks the entry cycle of every state; latency counts every busy cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            first_q     <= 1'b0;
            wr_cnt_q    <= '0;
            o_valid     <= 1'b0;
            o_error     <= 1'b0;
            o_err_stage <= 3'd0;
            o_latency   <= 32'd0;
        end else begin
            state_q  <= state_d;
            first_q  <= (state_d != state_q);
            wr_cnt_q <= (state_q == WRBACK) ? wr_cnt_q + AW'(1) : '0;
            if (accept) begin
                o_valid   <= 1'b0;
                o_error   <= 1'b0;
                o_latency <= 32'd0;
            end else begin
                if (o_busy && (o_latency != '1)) begin
                    o_latency <= o_latency + 32'd1;
                end
                if ((state_q == WRBACK) && (state_d == DONE)) begin
                    o_valid <= 1'b1;
                end
                if ((state_q != ERROR) && (state_d == ERROR)) begin
                    o_error     <= 1'b1;
                    o_err_stage <= state_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scoreboard bench for npu_seq_ctrl: randomized stage delays, reference latency
// model from per-stage durations, directed timeout/abort/reset scenarios.
module tb_npu_seq_ctrl;
    import npu_pkg::*;

    localparam int N       = 32;
    localparam int TIMEOUT = 100;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_valid, o_error;
    logic [2:0]  o_err_stage;
    logic [31:0] o_latency;

    logic [3:0]  done_drv = '0;
    logic [3:0]  spur     = '0;
    int          dly[4];
    bit   [3:0]  withhold   = '0;
    bit   [3:0]  coincident = '0;

    int n_vec  = 0;
    int n_miss = 0;
    int ls_cnt = 0;
    int exp_wr_q[$];
    int exp_lat_q[$];
    int exp_err_q[$];

    npu_seq_ctrl_if #(.N(N)) bus ();

    assign bus.i_load_done    = done_drv[0] | spur[0];
    assign bus.i_array_done   = done_drv[1] | spur[1];
    assign bus.i_quant_done   = done_drv[2] | spur[2];
    assign bus.i_softmax_done = done_drv[3] | spur[3];

    wire [3:0] starts = {bus.o_softmax_start, bus.o_quant_start, bus.o_array_start, bus.o_load_start};
    wire [NPU_ADDR_W-1:0] wr_addr = bus.o_wr_addr;

    npu_seq_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .bus         (bus),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_error     (o_error),
        .o_err_stage (o_err_stage),
        .o_latency   (o_latency)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(20, 1));
    endfunction

    // Each stage lasts (delay + 1) cycles; write-back lasts N cycles.
    task automatic applyStimulus(input int d0, input int d1, input int d2, input int d3,
                                 input bit hold, input bit expect_full);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        if (expect_full) begin
            for (int a = 0; a < N; a++) exp_wr_q.push_back(a);
            exp_lat_q.push_back((d0 + 1) + (d1 + 1) + (d2 + 1) + (d3 + 1) + N);
        end
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 if (!hold) i_start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_valid || o_error) break;
        end
        checkOutput("run_finished_in_budget", 32'(i < budget), 1);
    endtask

    task automatic waitStart(input int k, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (starts[k]) break;
        end
        checkOutput("stage_start_seen", 32'(i < budget), 1);
    endtask

    task automatic deliver(input int k);
        int d;
        d = dly[k];
        if (coincident[k]) begin
            done_drv[k] = 1'b1;
            @(posedge i_clk); #1 done_drv[k] = 1'b0;
            repeat (d - 1) @(posedge i_clk);
        end else begin
            repeat (d) @(posedge i_clk);
        end
        #1 done_drv[k] = 1'b1;
        @(posedge i_clk); #1 done_drv[k] = 1'b0;
    endtask

    initial begin : responder
        forever begin
            @(negedge i_clk);
            for (int k = 0; k < 4; k++) begin
                if (starts[k] && !withhold[k]) deliver(k);
            end
        end
    end

    initial begin : monitor
        logic prev_valid, prev_error;
        int   e;
        prev_valid = 1'b0;
        prev_error = 1'b0;
        forever begin
            @(negedge i_clk);
            if (bus.o_load_start) ls_cnt++;
            if (bus.o_wr_en) begin
                checkOutput("write_was_expected", 32'(exp_wr_q.size() > 0), 1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), e);
                end
            end
            if (o_valid && !prev_valid) begin
                checkOutput("valid_was_expected", 32'(exp_lat_q.size() > 0), 1);
                if (exp_lat_q.size() > 0) begin
                    e = exp_lat_q.pop_front();
                    checkOutput("latency", o_latency, e);
                end
            end
            if (o_error && !prev_error) begin
                checkOutput("error_was_expected", 32'(exp_err_q.size() > 0), 1);
                if (exp_err_q.size() > 0) begin
                    e = exp_err_q.pop_front();
                    checkOutput("err_stage", 32'(o_err_stage), e);
                end
            end
            prev_valid = o_valid;
            prev_error = o_error;
        end
    end

    initial begin : main
        int i, ls_base, cnt;
        #2;
        checkOutput("reset_busy",    32'(o_busy), 0);
        checkOutput("reset_valid",   32'(o_valid), 0);
        checkOutput("reset_latency", o_latency, 0);
        checkOutput("reset_wr_en",   32'(bus.o_wr_en), 0);
        #10 i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        $display("[TB] directed run, every done 5 cycles after its start");
        applyStimulus(5, 5, 5, 5, 1'b0, 1'b1);
        waitDone(400);
        checkOutput("latency_directed", o_latency, 56);
        repeat (5) @(negedge i_clk);
        checkOutput("done_valid_held",   32'(o_valid), 1);
        checkOutput("done_latency_held", o_latency, 56);
        checkOutput("done_not_busy",     32'(o_busy), 0);
        checkOutput("done_wr_addr_zero", 32'(wr_addr), 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b1);
            waitDone(500);
        end

        $display("[TB] start held high through a run, then restart from DONE");
        ls_base = ls_cnt;
        applyStimulus(rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b1);
        for (i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (bus.o_wr_en) break;
        end
        i_start = 1'b0;
        waitDone(300);
        checkOutput("held_start_single_run", 32'(ls_cnt - ls_base), 1);
        checkOutput("held_start_valid",      32'(o_valid), 1);
        applyStimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b1);
        @(negedge i_clk);
        checkOutput("restart_clears_valid", 32'(o_valid), 0);
        waitDone(500);

        $display("[TB] coincident quant done and spurious quant done in LOAD");
        coincident[2] = 1'b1;
        applyStimulus(8, rnd(), 4, rnd(), 1'b0, 1'b1);
        waitStart(0, 20);
        spur[2] = 1'b1;
        repeat (3) @(negedge i_clk);
        spur[2] = 1'b0;
        waitDone(500);
        coincident[2] = 1'b0;

        $display("[TB] array done withheld");
        withhold[1] = 1'b1;
        exp_err_q.push_back(2);
        applyStimulus(rnd(), 5, 5, 5, 1'b0, 1'b0);
        waitStart(1, 100);
        cnt = 0;
        for (i = 0; i < 300; i++) begin
            @(negedge i_clk);
            cnt++;
            if (o_error) break;
        end
        checkOutput("array_timeout_cycles", cnt, TIMEOUT);
        checkOutput("timeout_valid", 32'(o_valid), 0);
        checkOutput("timeout_busy",  32'(o_busy), 0);
        withhold[1] = 1'b0;
        applyStimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b1);
        @(negedge i_clk);
        checkOutput("start_clears_error", 32'(o_error), 0);
        waitDone(500);

        $display("[TB] abort at write 10");
        applyStimulus(2, 2, 2, 2, 1'b0, 1'b0);
        for (int a = 0; a < 10; a++) exp_wr_q.push_back(a);
        for (i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (bus.o_wr_en && wr_addr == 9) break;
        end
        checkOutput("reached_write_9", 32'(i < 300), 1);
        @(posedge i_clk); #1 i_abort = 1'b1;
        @(negedge i_clk);
        checkOutput("abort_wr_en_immediate", 32'(bus.o_wr_en), 0);
        @(posedge i_clk); #1 i_abort = 1'b0;
        @(negedge i_clk);
        checkOutput("abort_wr_en_next",  32'(bus.o_wr_en), 0);
        checkOutput("abort_idle",        32'(o_busy), 0);
        checkOutput("abort_valid",       32'(o_valid), 0);
        checkOutput("abort_wr_addr",     32'(wr_addr), 0);
        repeat (10) @(negedge i_clk);

        $display("[TB] reset during SOFTMAX");
        applyStimulus(3, 3, 3, 15, 1'b0, 1'b1);
        waitStart(3, 100);
        @(posedge i_clk); #3 i_rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy",      32'(o_busy), 0);
        checkOutput("midreset_softmax_st", 32'(bus.o_softmax_start), 0);
        checkOutput("midreset_latency",   o_latency, 0);
        checkOutput("midreset_err_stage", 32'(o_err_stage), 0);
        checkOutput("midreset_wr_en",     32'(bus.o_wr_en), 0);
        exp_wr_q.delete();
        exp_lat_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        checkOutput("postreset_valid", 32'(o_valid), 0);
        checkOutput("postreset_busy",  32'(o_busy), 0);
        applyStimulus(rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b1);
        waitDone(500);
        checkOutput("postreset_run_valid", 32'(o_valid), 1);

        repeat (3) @(negedge i_clk);
        checkOutput("writes_drained",  32'(exp_wr_q.size()), 0);
        checkOutput("latency_drained", 32'(exp_lat_q.size()), 0);
        checkOutput("errors_drained",  32'(exp_err_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not end, got hang, expected finish");
        $fatal(1, "[TB] global timeout");
    end
endmodule
